// File: rtl/host_ack_pkg.sv
// Shared constants and types for the host ACK generator/receiver pair.
// The fixed ACK frame is 9 bytes: a 64-bit key in bytes 0-7 and a flag in byte 8.
package host_ack_pkg;

    localparam logic [7:0]  ACK_FLAG_OK   = 8'hFF;
    localparam logic [7:0]  ACK_FLAG_FAIL = 8'h00;
    localparam logic [63:0] ACK_KEEP      = 64'h1FF;
    localparam logic [15:0] ACK_SIZE      = 16'd9;
    localparam logic [15:0] ACK_SRC_HOST  = 16'h0040;

    typedef struct packed {
        logic        result;
        logic [63:0] key;
    } ack_entry_t;

    typedef enum logic [0:0] {
        IDLE,
        DROP
    } ack_rx_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

    function automatic logic ack_flag_legal(input logic [7:0] flag);
        return (flag == ACK_FLAG_OK) || (flag == ACK_FLAG_FAIL);
    endfunction

endpackage

// File: rtl/host_ack_fifo.sv
// Synchronous FIFO of recovered ACK entries; the head is read straight from the
// storage registers, so a push is visible on the head one edge later.
module host_ack_fifo
    import host_ack_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  ack_entry_t                   push_entry,
    input  logic                         pop,
    output ack_entry_t                   head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ack_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_entry;
            end
        end
    end

endmodule

// File: rtl/host_ack_receiver.sv
// Validates single-beat 9-byte host ACKs and queues (key, result) pairs.
// Optional statistics counters are enabled by defining HOST_ACK_RX_STATS_EN.
module host_ack_receiver
    import host_ack_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] EXPECT_SRC = 16'h0040,
    parameter bit          CHECK_SRC  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_axis_ack_valid,
    output logic          s_axis_ack_ready,
    input  logic [511:0]  s_axis_ack_data,
    input  logic          s_axis_ack_last,
    input  logic [63:0]   s_axis_ack_keep,
    input  logic [15:0]   s_axis_ack_size,
    input  logic [15:0]   s_axis_ack_src,
    input  logic [15:0]   s_axis_ack_dst,
    output logic          m_axis_key_udp_valid,
    output logic [63:0]   m_axis_key_udp,
    output logic          m_axis_key_udp_result,
    input  logic          m_axis_key_udp_ready
`ifdef HOST_ACK_RX_STATS_EN
    ,
    output logic [31:0]   stat_ack_ok,
    output logic [31:0]   stat_ack_err
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    ack_rx_state_t    state_q, state_d;
    logic             xfer;
    logic             beat_good;
    logic             push;
    logic             beat_ok;
    logic             beat_err;
    ack_entry_t       push_entry;
    ack_entry_t       head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       flag;

    assign flag = s_axis_ack_data[71:64];

    // Ready follows the registered fill level; a same-cycle pop is not credited.
    assign s_axis_ack_ready = (state_q == DROP) || !fifo_full;
    assign xfer             = s_axis_ack_valid && s_axis_ack_ready;

    assign beat_good = (s_axis_ack_size == ACK_SIZE) &&
                       (s_axis_ack_keep == ACK_KEEP) &&
                       ack_flag_legal(flag) &&
                       (!CHECK_SRC || (s_axis_ack_src == EXPECT_SRC));

    assign push_entry.result = (flag == ACK_FLAG_OK);
    assign push_entry.key    = s_axis_ack_data[63:0];

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        beat_ok  = 1'b0;
        beat_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (!s_axis_ack_last) begin
                        state_d  = DROP;
                        beat_err = 1'b1;
                    end else if (beat_good) begin
                        push    = 1'b1;
                        beat_ok = 1'b1;
                    end else begin
                        beat_err = 1'b1;
                    end
                end
            end
            DROP: begin
                if (xfer && s_axis_ack_last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    host_ack_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (m_axis_key_udp_ready),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign m_axis_key_udp_valid  = !fifo_empty;
    assign m_axis_key_udp        = head.key;
    assign m_axis_key_udp_result = head.result;

`ifdef HOST_ACK_RX_STATS_EN
    logic [31:0] ok_q;
    logic [31:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ok_q  <= '0;
            err_q <= '0;
        end else begin
            if (beat_ok) begin
                ok_q <= sat_inc32(ok_q);
            end
            if (beat_err) begin
                err_q <= sat_inc32(err_q);
            end
        end
    end

    assign stat_ack_ok  = ok_q;
    assign stat_ack_err = err_q;

    logic unused_sig;
    assign unused_sig = ^{s_axis_ack_data[511:72], s_axis_ack_dst, fifo_count};
`else
    logic unused_sig;
    assign unused_sig = ^{s_axis_ack_data[511:72], s_axis_ack_dst, fifo_count,
                          beat_ok, beat_err};
`endif

endmodule

// File: tb/tb_host_ack_receiver.sv
// Self-checking bench for host_ack_receiver: vector table, directed corner cases
// and randomized traffic compared against a queue-based reference model.
module tb_host_ack_receiver;
    import host_ack_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic         ready;
    logic [511:0] data = '0;
    logic         last = 1'b0;
    logic [63:0]  keep = '0;
    logic [15:0]  size = '0;
    logic [15:0]  src = '0;
    logic [15:0]  dst = '0;
    logic         out_valid;
    logic [63:0]  out_key;
    logic         out_result;
    logic         key_ready = 1'b1;

    logic         b_valid = 1'b0;
    logic         b_ready;
    logic         b_out_valid;
    logic [63:0]  b_out_key;
    logic         b_out_result;

`ifdef HOST_ACK_RX_STATS_EN
    logic [31:0]  stat_ok, stat_err, b_stat_ok, b_stat_err;
`endif

    always #5 clk = ~clk;

    host_ack_receiver #(
        .FIFO_DEPTH (DEPTH),
        .EXPECT_SRC (16'h0040),
        .CHECK_SRC  (1'b1)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .s_axis_ack_valid      (valid),
        .s_axis_ack_ready      (ready),
        .s_axis_ack_data       (data),
        .s_axis_ack_last       (last),
        .s_axis_ack_keep       (keep),
        .s_axis_ack_size       (size),
        .s_axis_ack_src        (src),
        .s_axis_ack_dst        (dst),
        .m_axis_key_udp_valid  (out_valid),
        .m_axis_key_udp        (out_key),
        .m_axis_key_udp_result (out_result),
        .m_axis_key_udp_ready  (key_ready)
`ifdef HOST_ACK_RX_STATS_EN
        ,
        .stat_ack_ok           (stat_ok),
        .stat_ack_err          (stat_err)
`endif
    );

    host_ack_receiver #(
        .FIFO_DEPTH (DEPTH),
        .EXPECT_SRC (16'h0040),
        .CHECK_SRC  (1'b0)
    ) dut_nosrc (
        .clk                   (clk),
        .rst                   (rst),
        .s_axis_ack_valid      (b_valid),
        .s_axis_ack_ready      (b_ready),
        .s_axis_ack_data       (data),
        .s_axis_ack_last       (last),
        .s_axis_ack_keep       (keep),
        .s_axis_ack_size       (size),
        .s_axis_ack_src        (src),
        .s_axis_ack_dst        (dst),
        .m_axis_key_udp_valid  (b_out_valid),
        .m_axis_key_udp        (b_out_key),
        .m_axis_key_udp_result (b_out_result),
        .m_axis_key_udp_ready  (1'b1)
`ifdef HOST_ACK_RX_STATS_EN
        ,
        .stat_ack_ok           (b_stat_ok),
        .stat_ack_err          (b_stat_err)
`endif
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: queue of pending entries plus a "discarding" flag.
    ack_entry_t  mq[$];
    bit          m_drop;
    int unsigned m_ok;
    int unsigned m_err;

    typedef struct {
        logic [63:0] key;
        logic [7:0]  flag;
        logic [15:0] size;
        logic [63:0] keep;
        logic [15:0] src;
        logic        exp_good;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_good(input bit check_src);
        logic [7:0] f;
        f = data[71:64];
        return (size == 16'd9) && (keep == 64'h1FF) && (f == 8'hFF || f == 8'h00) &&
               (!check_src || src == 16'h0040);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_drop = 1'b0;
        m_ok   = 0;
        m_err  = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, step past the rising edge.
    task automatic cycle();
        bit         m_rdy;
        bit         xfer;
        ack_entry_t e;
        @(negedge clk);
        m_rdy = m_drop || (mq.size() < DEPTH);
        chk("ready", ready, m_rdy);
        chk("valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("key", out_key, mq[0].key);
            chk("result", out_result, mq[0].result);
        end
`ifdef HOST_ACK_RX_STATS_EN
        chk("stat_ok", stat_ok, m_ok);
        chk("stat_err", stat_err, m_err);
`endif
        if (rst) begin
            model_reset();
        end else begin
            xfer = valid && m_rdy;
            if (mq.size() != 0 && key_ready) void'(mq.pop_front());
            if (xfer) begin
                if (m_drop) begin
                    if (last) m_drop = 1'b0;
                end else if (!last) begin
                    m_drop = 1'b1;
                    m_err++;
                end else if (model_good(1'b1)) begin
                    e.result = (data[71:64] == 8'hFF);
                    e.key    = data[63:0];
                    mq.push_back(e);
                    m_ok++;
                end else begin
                    m_err++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] k, input logic [7:0] f, input logic [15:0] sz,
                        input logic [63:0] kp, input logic [15:0] sr, input logic lst);
        for (int i = 0; i < 16; i++) data[i*32 +: 32] = $urandom;
        data[63:0]  = k;
        data[71:64] = f;
        size  = sz;
        keep  = kp;
        src   = sr;
        dst   = 16'($urandom);
        last  = lst;
        valid = 1'b1;
    endtask

    task automatic good(input logic [63:0] k);
        beat(k, 8'hFF, 16'd9, 64'h1FF, 16'h0040, 1'b1);
    endtask

    initial begin
        tbl[0] = '{64'h0123_4567_89AB_CDEF, 8'hFF, 16'd9, 64'h1FF, 16'h0040, 1'b1};
        tbl[1] = '{64'h0123_4567_89AB_CDEF, 8'h00, 16'd9, 64'h1FF, 16'h0040, 1'b1};
        tbl[2] = '{64'h0123_4567_89AB_CDEF, 8'h5A, 16'd9, 64'h1FF, 16'h0040, 1'b0};
        tbl[3] = '{64'h1111_2222_3333_4444, 8'hFF, 16'd8, 64'h1FF, 16'h0040, 1'b0};
        tbl[4] = '{64'h5555_6666_7777_8888, 8'hFF, 16'd9, 64'h0FF, 16'h0040, 1'b0};
        tbl[5] = '{64'h9999_AAAA_BBBB_CCCC, 8'h00, 16'd9, 64'h1FF, 16'h0001, 1'b0};
        tbl[6] = '{64'hDEAD_BEEF_CAFE_F00D, 8'h00, 16'd9, 64'h1FF, 16'h0040, 1'b1};

        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", ready, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_key", out_key, 64'h0);
        chk("rst_result", out_result, 1'b0);
`ifdef HOST_ACK_RX_STATS_EN
        chk("rst_stat_ok", stat_ok, 32'd0);
        chk("rst_stat_err", stat_err, 32'd0);
`endif

        // Table of single-beat packets, consumer always ready.
        key_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            beat(tbl[i].key, tbl[i].flag, tbl[i].size, tbl[i].keep, tbl[i].src, 1'b1);
            cycle();
            valid = 1'b0;
            chk("tbl_valid", out_valid, tbl[i].exp_good);
            if (tbl[i].exp_good) begin
                chk("tbl_key", out_key, tbl[i].key);
                chk("tbl_result", out_result, tbl[i].flag == 8'hFF);
            end
            cycle();
        end

        // Foreign src accepted when source checking is disabled; bad keep still dropped.
        beat(64'hA5A5_0000_1234_5678, 8'hFF, 16'd9, 64'h1FF, 16'h0001, 1'b1);
        valid = 1'b0;
        b_valid = 1'b1;
        cycle();
        b_valid = 1'b0;
        chk("nosrc_valid", b_out_valid, 1'b1);
        chk("nosrc_key", b_out_key, 64'hA5A5_0000_1234_5678);
        chk("nosrc_result", b_out_result, 1'b1);
        cycle();
        chk("nosrc_drain", b_out_valid, 1'b0);
        beat(64'h1, 8'hFF, 16'd9, 64'h0FF, 16'h0001, 1'b1);
        valid = 1'b0;
        b_valid = 1'b1;
        cycle();
        b_valid = 1'b0;
        chk("nosrc_badkeep", b_out_valid, 1'b0);

        // Three-beat packet is discarded whole, then a good ACK goes through.
        good(64'h0BAD_0BAD_0BAD_0BAD);
        last = 1'b0;
        cycle();
        good(64'h0BAD_0BAD_0BAD_0BAD);
        last = 1'b0;
        cycle();
        good(64'h0BAD_0BAD_0BAD_0BAD);
        cycle();
        valid = 1'b0;
        chk("multi_none", out_valid, 1'b0);
        good(64'hFEED_FACE_0000_0001);
        cycle();
        valid = 1'b0;
        chk("multi_after", out_valid, 1'b1);
        chk("multi_key", out_key, 64'hFEED_FACE_0000_0001);
        cycle();

        // Backpressure: fill to depth, fifth ACK waits until a pop has been registered.
        key_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            good(64'h100 + 64'(i));
            cycle();
        end
        good(64'h104);
        chk("full_ready", ready, 1'b0);
        cycle();
        key_ready = 1'b1;
        chk("full_ready_pop", ready, 1'b0);
        cycle();
        chk("after_pop_ready", ready, 1'b1);
        cycle();
        valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("drained", out_valid, 1'b0);

        // Simultaneous push and pop at count 2 leaves two entries.
        key_ready = 1'b0;
        good(64'h200);
        cycle();
        good(64'h201);
        cycle();
        good(64'h202);
        key_ready = 1'b1;
        cycle();
        valid = 1'b0;
        key_ready = 1'b0;
        cycle();
        key_ready = 1'b1;
        cycle();
        chk("pp_one_left", out_valid, 1'b1);
        chk("pp_one_key", out_key, 64'h202);
        cycle();
        chk("pp_empty", out_valid, 1'b0);

        // Reset while three entries are queued and the block is discarding.
        key_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            good(64'h300 + 64'(i));
            cycle();
        end
        good(64'h3FF);
        last = 1'b0;
        cycle();
        valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ready", ready, 1'b1);
`ifdef HOST_ACK_RX_STATS_EN
        chk("mid_rst_ok", stat_ok, 32'd0);
        chk("mid_rst_err", stat_err, 32'd0);
`endif
        key_ready = 1'b1;
        good(64'h0123_4567_89AB_CDEF);
        cycle();
        valid = 1'b0;
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_key", out_key, 64'h0123_4567_89AB_CDEF);
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [7:0]  f;
            logic [15:0] sz;
            logic [63:0] kp;
            logic [15:0] sr;
            int unsigned r;
            r  = $urandom_range(0, 15);
            f  = (r < 6) ? 8'hFF : (r < 12) ? 8'h00 : 8'(($urandom_range(1, 254)));
            sz = ($urandom_range(0, 9) == 0) ? 16'd8 : 16'd9;
            kp = ($urandom_range(0, 9) == 0) ? 64'h0FF : 64'h1FF;
            sr = ($urandom_range(0, 9) == 0) ? 16'h0001 : 16'h0040;
            beat({$urandom, $urandom}, f, sz, kp, sr, $urandom_range(0, 5) != 0);
            valid     = ($urandom_range(0, 3) != 0);
            key_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        valid = 1'b0;
        key_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
